ps2_scancode_rx: RTL

- Upstream keyboard front-end for the TinyBASIC video top level.
- Samples the raw PS/2 clock and data pins in the 25 MHz domain, deglitches them, and deframes 11-bit PS/2 device-to-host frames.
- Checks odd parity and the stop bit.
- Buffers good scancodes in a small FIFO and presents them to the terminal/keyboard logic over a valid/ready handshake.

---
 rtl/ps2_scancode_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronise, deglitch, deframe, FIFO.
// Good scancodes are offered to the consumer over a valid/ready handshake.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK_25MHZ,
    input  logic       RESET_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCAN_DATA,
    output logic       SCAN_VALID,
    input  logic       SCAN_READY,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       OVERFLOW
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic          clk_s1, clk_s2;
    logic          dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          par_ok, par_ok_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic          timeout;
    logic          push;
    logic          par_err_n, frm_err_n;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, pop, do_push, ovf_n;

    // Filtered level only moves after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DATA;
            dat_s2 <= dat_s1;
            fall   <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        par_ok_n  = par_ok;
        push      = 1'b0;
        par_err_n = 1'b0;
        frm_err_n = 1'b0;
        timeout   = (state != IDLE) && !fall &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));
        to_cnt_n  = (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
        if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n  = DATA;
                        bitcnt_n = '0;
                    end
                end
                DATA: begin
                    shreg_n  = {dat_s2, shreg[7:1]};
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_ok_n = ^shreg ^ dat_s2;
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!dat_s2)     frm_err_n = 1'b1;
                    else if (par_ok) push      = 1'b1;
                    else             par_err_n = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n   = IDLE;
            frm_err_n = 1'b1;
        end
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            par_ok     <= 1'b0;
            to_cnt     <= '0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            par_ok     <= par_ok_n;
            to_cnt     <= to_cnt_n;
            PARITY_ERR <= par_err_n;
            FRAME_ERR  <= frm_err_n;
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && SCAN_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push && (!full || pop);
    assign ovf_n   = push && full && !pop;

    assign SCAN_VALID = !empty;
    assign SCAN_DATA  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK_25MHZ) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            OVERFLOW <= ovf_n;
        end
    end

endmodule
